// File: rtl/maze_game_core.sv
//------------------------------------------------------------------------------
// Module      : maze_game_core
// Description : Seven-room directional adventure responder with sword,
//               move counter and sticky dead/win status.
//               Optional move budget enabled by defining GAME_MOVE_LIMIT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module maze_game_core #(
    parameter int MAX_MOVES = 32,
    parameter int CNT_W     = 6
) (
    input  logic             clock,
    input  logic             R_n,
    input  logic             n,
    input  logic             s,
    input  logic             e,
    input  logic             w,
    output logic             d,
    output logic             win,
    output logic [2:0]       room,
    output logic             sword,
    output logic [CNT_W-1:0] moves
);

    localparam logic [2:0] C_CAVE   = 3'd0;
    localparam logic [2:0] C_TUNNEL = 3'd1;
    localparam logic [2:0] C_RIVER  = 3'd2;
    localparam logic [2:0] C_STASH  = 3'd3;
    localparam logic [2:0] C_DEN    = 3'd4;
    localparam logic [2:0] C_VAULT  = 3'd5;
    localparam logic [2:0] C_GRAVE  = 3'd6;

    localparam logic [3:0] C_DIR_N = 4'b1000;
    localparam logic [3:0] C_DIR_S = 4'b0100;
    localparam logic [3:0] C_DIR_E = 4'b0010;
    localparam logic [3:0] C_DIR_W = 4'b0001;

    localparam logic [CNT_W-1:0] C_MOVES_SAT = {CNT_W{1'b1}};

    logic [2:0]       r_room;
    logic             r_sword;
    logic [CNT_W-1:0] r_moves;

    logic [2:0]       w_room_nxt;
    logic             w_sword_nxt;
    logic [CNT_W-1:0] w_moves_nxt;
    logic [3:0]       w_dir;
    logic             w_single;
    logic             w_roaming;
    logic             w_limit;

    assign w_dir     = {n, s, e, w};
    // Exactly one request bit: nonzero and a power of two.
    assign w_single  = (w_dir != 4'd0) && ((w_dir & (w_dir - 4'd1)) == 4'd0);
    assign w_roaming = (r_room == C_CAVE) || (r_room == C_TUNNEL) ||
                       (r_room == C_RIVER) || (r_room == C_STASH);

`ifdef GAME_MOVE_LIMIT_EN
    localparam logic [CNT_W-1:0] C_MAX_MOVES = CNT_W'(MAX_MOVES);
    assign w_limit = w_roaming && (r_moves == C_MAX_MOVES);
`else
    assign w_limit = 1'b0;
`endif

    always_comb begin
        w_room_nxt  = r_room;
        w_moves_nxt = r_moves;
        if (w_limit) begin
            w_room_nxt = C_GRAVE;
        end else begin
            case (r_room)
                C_CAVE, C_TUNNEL, C_RIVER, C_STASH: begin
                    if (w_single) begin
                        if (r_moves != C_MOVES_SAT) begin
                            w_moves_nxt = r_moves + CNT_W'(1);
                        end
                        // Unlisted directions are walls: counted, room unchanged.
                        case (r_room)
                            C_CAVE: begin
                                if (w_dir == C_DIR_E) w_room_nxt = C_TUNNEL;
                            end
                            C_TUNNEL: begin
                                if (w_dir == C_DIR_W) w_room_nxt = C_CAVE;
                                if (w_dir == C_DIR_S) w_room_nxt = C_RIVER;
                            end
                            C_RIVER: begin
                                if (w_dir == C_DIR_N) w_room_nxt = C_TUNNEL;
                                if (w_dir == C_DIR_W) w_room_nxt = C_STASH;
                                if (w_dir == C_DIR_E) w_room_nxt = C_DEN;
                            end
                            C_STASH: begin
                                if (w_dir == C_DIR_E) w_room_nxt = C_RIVER;
                            end
                            default: w_room_nxt = r_room;
                        endcase
                    end
                end
                C_DEN:            w_room_nxt = r_sword ? C_VAULT : C_GRAVE;
                C_VAULT, C_GRAVE: w_room_nxt = r_room;
                default:          w_room_nxt = C_GRAVE;
            endcase
        end
    end

    assign w_sword_nxt = r_sword | (w_room_nxt == C_STASH);

    always_ff @(posedge clock or negedge R_n) begin
        if (!R_n) begin
            r_room  <= C_CAVE;
            r_sword <= 1'b0;
            r_moves <= '0;
        end else begin
            r_room  <= w_room_nxt;
            r_sword <= w_sword_nxt;
            r_moves <= w_moves_nxt;
        end
    end

    assign room  = r_room;
    assign sword = r_sword;
    assign moves = r_moves;
    assign d     = (r_room == C_GRAVE);
    assign win   = (r_room == C_VAULT);

endmodule

`default_nettype wire
